// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master (I-fetch / D-cache) front end for the single
// tagged memory bus. Request and return paths are purely combinational; only
// the tag-owner table and the I-side starvation counter are registered.
module mem_bus_arbiter #(
  parameter int NUM_TAGS         = 16,
  parameter int STARVE_LIMIT     = 4,
  parameter int XLEN             = 32,
  // Flags data returns that carry a tag nobody owns. Integrations that
  // deliberately present stray or post-reset tags can switch it off.
  parameter bit CHECK_STRAY_TAGS = 1'b1
) (
  input  logic            clock,
  input  logic            reset,

  input  logic [1:0]      icache_cmd,
  input  logic [XLEN-1:0] icache_addr,
  output logic [3:0]      icache_response,
  output logic [63:0]     icache_data,
  output logic [3:0]      icache_tag,

  input  logic [1:0]      dcache_cmd,
  input  logic [XLEN-1:0] dcache_addr,
  input  logic [63:0]     dcache_wdata,
  output logic [3:0]      dcache_response,
  output logic [63:0]     dcache_data,
  output logic [3:0]      dcache_tag,

  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  localparam logic [4:0]    NUM_TAGS_W = 5'(NUM_TAGS);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Registered bookkeeping
  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;   // 0 = I-side, 1 = D-side
  logic [SW-1:0]       starve_q, starve_d;

  // Combinational request/grant signals
  logic i_req, d_req;
  logic grant_i, grant_d;
  logic starve_hit;

  // Return / allocate decode
  logic             ret_in_range, ret_hit, ret_owner_d;
  logic [IDX_W-1:0] ret_idx;
  logic             alloc;
  logic [IDX_W-1:0] alloc_idx;
  logic [NUM_TAGS-1:0] clr_vec, set_vec;

  // Arbitration: D-side normally wins, I-side wins once it has starved long enough
  always_comb begin
    i_req      = (icache_cmd == BUS_LOAD);
    d_req      = (dcache_cmd == BUS_LOAD) || (dcache_cmd == BUS_STORE);
    starve_hit = (starve_q == STARVE_MAX);
    grant_d    = d_req && !(i_req && starve_hit);
    grant_i    = i_req && !grant_d;
  end

  // Forward the granted master onto the memory bus
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_i) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = icache_addr;
    end else if (grant_d) begin
      proc2mem_command = dcache_cmd;
      proc2mem_addr    = dcache_addr;
      proc2mem_data    = dcache_wdata;
    end
  end

  // Route the memory acceptance tag back to whichever master was granted
  always_comb begin
    icache_response = grant_i ? mem2proc_response : 4'd0;
    dcache_response = grant_d ? mem2proc_response : 4'd0;
  end

  // Look up the owner of a returning tag and steer the tag to that master
  always_comb begin
    ret_in_range = (mem2proc_tag != 4'd0) && ({1'b0, mem2proc_tag} < NUM_TAGS_W);
    ret_idx      = mem2proc_tag[IDX_W-1:0];
    ret_hit      = ret_in_range && valid_q[ret_idx];
    ret_owner_d  = owner_q[ret_idx];
    icache_tag   = (ret_hit && !ret_owner_d) ? mem2proc_tag : 4'd0;
    dcache_tag   = (ret_hit &&  ret_owner_d) ? mem2proc_tag : 4'd0;
    // Data goes to both sides; the tag alone says whether it is meant for them.
    icache_data  = mem2proc_data;
    dcache_data  = mem2proc_data;
  end

  // Only accepted loads allocate an owner entry; stores never get data back
  always_comb begin
    alloc     = (grant_i || (grant_d && (dcache_cmd == BUS_LOAD)))
                && (mem2proc_response != 4'd0)
                && ({1'b0, mem2proc_response} < NUM_TAGS_W);
    alloc_idx = mem2proc_response[IDX_W-1:0];
  end

  // Per-entry clear/set strobes
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAGS; gi++) begin : g_entry
      assign clr_vec[gi] = ret_in_range && (ret_idx == IDX_W'(gi));
      assign set_vec[gi] = alloc && (alloc_idx == IDX_W'(gi));
    end
  endgenerate

  // Owner table next state: clear on return first, then set on allocate, so a
  // tag reused in its own return cycle ends up owned by the new requester
  always_comb begin
    valid_d = (valid_q & ~clr_vec) | set_vec;
    owner_d = (owner_q & ~set_vec) | (set_vec & {NUM_TAGS{grant_d}});
  end

  // Starvation counter: count I-side losses to the D-side, hold while memory
  // rejects an I-side grant, otherwise clear
  always_comb begin
    starve_d = '0;
    if (i_req && grant_d) begin
      starve_d = starve_hit ? starve_q : starve_q + SW'(1);
    end else if (grant_i && (mem2proc_response == 4'd0)) begin
      starve_d = starve_q;
    end
  end

  // Bookkeeping registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q  <= '0;
      owner_q  <= '0;
      starve_q <= '0;
    end else begin
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

`ifndef SYNTHESIS
  generate
    if (CHECK_STRAY_TAGS) begin : g_stray_chk
      // A nonzero returning tag should always belong to an outstanding load
      always_ff @(posedge clock) begin
        if (reset && (mem2proc_tag != 4'd0)) begin
          assert (ret_hit)
            else $error("mem_bus_arbiter: return tag %0d has no owner, dropped", mem2proc_tag);
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random
// traffic, all compared against an owner/starvation model kept in plain ints.
module tb_mem_bus_arbiter;

  localparam int XLEN = 32;
  localparam int NT   = 16;
  localparam int SL   = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      icache_cmd = '0;
  logic [XLEN-1:0] icache_addr = '0;
  logic [3:0]      icache_response;
  logic [63:0]     icache_data;
  logic [3:0]      icache_tag;
  logic [1:0]      dcache_cmd = '0;
  logic [XLEN-1:0] dcache_addr = '0;
  logic [63:0]     dcache_wdata = '0;
  logic [3:0]      dcache_response;
  logic [63:0]     dcache_data;
  logic [3:0]      dcache_tag;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response = '0;
  logic [63:0]     mem2proc_data = '0;
  logic [3:0]      mem2proc_tag = '0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(
    .NUM_TAGS(NT), .STARVE_LIMIT(SL), .XLEN(XLEN), .CHECK_STRAY_TAGS(1'b0)
  ) dut (
    .clock(clock), .reset(reset),
    .icache_cmd(icache_cmd), .icache_addr(icache_addr),
    .icache_response(icache_response), .icache_data(icache_data), .icache_tag(icache_tag),
    .dcache_cmd(dcache_cmd), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_response(dcache_response), .dcache_data(dcache_data), .dcache_tag(dcache_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag)
  );

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  // Reference model: owner of each tag (0 none, 1 I, 2 D) and I-side loss streak
  int own [NT];
  int starve = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) own[t] = 0;
    starve = 0;
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, advance model
  task automatic cyc(input logic [1:0] ic, input logic [31:0] ia,
                     input logic [1:0] dc, input logic [31:0] da, input logic [63:0] wd,
                     input logic [3:0] rsp, input logic [63:0] rd, input logic [3:0] rt,
                     input logic rn);
    int win;
    bit ir, dr;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_pdata;
    logic [3:0]  e_iresp, e_dresp, e_itag, e_dtag;
    @(negedge clock);
    icache_cmd = ic; icache_addr = ia;
    dcache_cmd = dc; dcache_addr = da; dcache_wdata = wd;
    mem2proc_response = rsp; mem2proc_data = rd; mem2proc_tag = rt;
    reset = rn;
    #2;
    ir = (ic == 2'd1);
    dr = (dc == 2'd1) || (dc == 2'd2);
    if (ir && dr) win = (starve == SL) ? 1 : 2;
    else if (ir)  win = 1;
    else if (dr)  win = 2;
    else          win = 0;
    e_cmd   = (win == 1) ? 2'd1 : (win == 2) ? dc : 2'd0;
    e_addr  = (win == 1) ? ia : (win == 2) ? da : 32'd0;
    e_pdata = (win == 2) ? wd : 64'd0;
    e_iresp = (win == 1) ? rsp : 4'd0;
    e_dresp = (win == 2) ? rsp : 4'd0;
    e_itag  = (rt != 0 && own[rt] == 1) ? rt : 4'd0;
    e_dtag  = (rt != 0 && own[rt] == 2) ? rt : 4'd0;
    check_eq("cmd",   64'(proc2mem_command), 64'(e_cmd));
    check_eq("addr",  64'(proc2mem_addr),    64'(e_addr));
    check_eq("pdata", proc2mem_data,         e_pdata);
    check_eq("iresp", 64'(icache_response),  64'(e_iresp));
    check_eq("dresp", 64'(dcache_response),  64'(e_dresp));
    check_eq("itag",  64'(icache_tag),       64'(e_itag));
    check_eq("dtag",  64'(dcache_tag),       64'(e_dtag));
    check_eq("idata", icache_data,           rd);
    check_eq("ddata", dcache_data,           rd);
    $display("cyc %0d rst_n=%0b ic=%0d dc=%0d rsp=%0d rt=%0d win=%0d itag=%0d dtag=%0d starve=%0d",
             cyc_no, rn, ic, dc, rsp, rt, win, icache_tag, dcache_tag, starve);
    if (!rn) begin
      model_reset();
    end else begin
      if (rt != 0) own[rt] = 0;
      if (rsp != 0 && (win == 1 || (win == 2 && dc == 2'd1))) own[rsp] = win;
      if (ir && win == 2)                  starve = (starve < SL) ? starve + 1 : SL;
      else if (ir && win == 1 && rsp == 0) starve = starve;
      else                                 starve = 0;
    end
    cyc_no++;
  endtask

  task automatic idle(input logic [3:0] rt);
    cyc(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, rt, 1'b1);
  endtask

  initial begin
    logic [1:0] ic, dc;
    logic [3:0] rsp, rt;
    model_reset();

    // Reset with idle inputs: bus idle, no tags
    cyc(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0, 1'b0);
    cyc(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0, 1'b0);
    check_eq("rst_cmd", 64'(proc2mem_command), 64'd0);
    idle(4'd0);

    // I-side load 0x100 accepted as tag 3, data returns two cycles later
    cyc(2'd1, 32'h100, 2'd0, 32'd0, 64'd0, 4'd3, 64'd0, 4'd0, 1'b1);
    check_eq("t1_iresp", 64'(icache_response), 64'd3);
    check_eq("t1_addr",  64'(proc2mem_addr),   64'h100);
    idle(4'd0);
    cyc(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'hDEAD, 4'd3, 1'b1);
    check_eq("t1_itag",  64'(icache_tag), 64'd3);
    check_eq("t1_idata", icache_data,     64'hDEAD);
    check_eq("t1_dtag",  64'(dcache_tag), 64'd0);

    // D-side store: forwarded with data, no owner entry, return dropped
    cyc(2'd0, 32'd0, 2'd2, 32'h200, 64'h1234, 4'd5, 64'd0, 4'd0, 1'b1);
    check_eq("t3_cmd",   64'(proc2mem_command), 64'd2);
    check_eq("t3_pdata", proc2mem_data,         64'h1234);
    idle(4'd0);
    cyc(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'h55, 4'd5, 1'b1);
    check_eq("t3_itag", 64'(icache_tag), 64'd0);
    check_eq("t3_dtag", 64'(dcache_tag), 64'd0);

    // Both sides load every cycle, memory always accepts: D,D,D,D,I repeating
    idle(4'd0);
    for (int k = 0; k < 10; k++) begin
      cyc(2'd1, 32'h1000 + 32'(k * 8), 2'd1, 32'h2000 + 32'(k * 8), 64'd0,
          4'(8 + (k % 4)), 64'd0, 4'd0, 1'b1);
      check_eq("t2_igrant", 64'(icache_response != 0), 64'((k % 5) == 4));
      check_eq("t2_dgrant", 64'(dcache_response != 0), 64'((k % 5) != 4));
    end

    // Memory rejects the forced I-side grant: I stays granted next cycle
    idle(4'd0);
    for (int k = 0; k < 4; k++)
      cyc(2'd1, 32'h3000, 2'd1, 32'h4000, 64'd0, 4'd9, 64'd0, 4'd0, 1'b1);
    cyc(2'd1, 32'h3000, 2'd1, 32'h4000, 64'd0, 4'd0, 64'd0, 4'd0, 1'b1);
    check_eq("t4_rej_addr", 64'(proc2mem_addr), 64'h3000);
    cyc(2'd1, 32'h3000, 2'd1, 32'h4000, 64'd0, 4'd10, 64'd0, 4'd0, 1'b1);
    check_eq("t4_hold_addr",  64'(proc2mem_addr),   64'h3000);
    check_eq("t4_hold_iresp", 64'(icache_response), 64'd10);
    check_eq("t4_hold_dresp", 64'(dcache_response), 64'd0);

    // Tag 7 returns to I in the same cycle D allocates tag 7
    idle(4'd0);
    cyc(2'd1, 32'h500, 2'd0, 32'd0, 64'd0, 4'd7, 64'd0, 4'd0, 1'b1);
    cyc(2'd0, 32'd0, 2'd1, 32'h600, 64'd0, 4'd7, 64'hA7, 4'd7, 1'b1);
    check_eq("t5_itag",  64'(icache_tag),      64'd7);
    check_eq("t5_dresp", 64'(dcache_response), 64'd7);
    idle(4'd7);
    check_eq("t5_dtag2", 64'(dcache_tag), 64'd7);
    check_eq("t5_itag2", 64'(icache_tag), 64'd0);

    // Reset discards outstanding tags 1..3
    cyc(2'd1, 32'h700, 2'd0, 32'd0, 64'd0, 4'd1, 64'd0, 4'd0, 1'b1);
    cyc(2'd0, 32'd0, 2'd1, 32'h708, 64'd0, 4'd2, 64'd0, 4'd0, 1'b1);
    cyc(2'd1, 32'h710, 2'd0, 32'd0, 64'd0, 4'd3, 64'd0, 4'd0, 1'b1);
    cyc(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0, 1'b0);
    for (int t = 1; t <= 3; t++) begin
      idle(4'(t));
      check_eq("t6_itag", 64'(icache_tag), 64'd0);
      check_eq("t6_dtag", 64'(dcache_tag), 64'd0);
    end

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      ic  = 2'($urandom_range(0, 2));
      dc  = 2'($urandom_range(0, 2));
      rsp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rt  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      cyc(ic, {$urandom()} & 32'hFFFF_FFF8, dc, {$urandom()} & 32'hFFFF_FFF8,
          {$urandom(), $urandom()}, rsp, {$urandom(), $urandom()}, rt,
          ($urandom_range(0, 49) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
